// File: rtl/log_mul_pkg.sv
// Shared types and constants for the Mitchell log-domain FP multiplier.
package log_mul_pkg;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

  localparam int FLAG_NV = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_UF = 0;

  localparam int MAX_W = 64;

  // Quiet NaN with positive sign, all-ones exponent and only the mantissa MSB set.
  function automatic logic [MAX_W-1:0] canon_nan(input int exp_w, input int man_w);
    logic [MAX_W-1:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/log_mul_classify.sv
// Unpacks one IEEE-style operand into sign/exponent/mantissa and its class.
module log_mul_classify
  import log_mul_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic [EXP_W+MAN_W:0] word,
  output logic                 s,
  output logic [EXP_W-1:0]     e,
  output logic [MAN_W-1:0]     m,
  output fp_class_t            cls
);

  assign s = word[EXP_W+MAN_W];
  assign e = word[EXP_W+MAN_W-1:MAN_W];
  assign m = word[MAN_W-1:0];

  // Denormals collapse to ZERO; the mantissa is simply never consumed for them.
  always_comb begin
    cls = NORM;
    if (e == '0)
      cls = ZERO;
    else if (&e)
      cls = (m == '0) ? INF : NAN;
  end

endmodule

// File: rtl/log_fp_mul_pipe.sv
// Three-stage Mitchell approximate FP multiplier with global valid/ready stall.
// Build option: define LOG_MUL_CORR_EN to add the no-carry cross-term correction.
module log_fp_mul_pipe
  import log_mul_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_p,
  output logic [2:0]           out_flags
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int BIAS   = 2**(EXP_W-1) - 1;
  localparam int EW     = EXP_W + 2;
  localparam int STAGES = 3;

  localparam logic [W-1:0]         QNAN  = W'(canon_nan(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] EMAX  = EW'(2**EXP_W - 1);
  localparam logic signed [EW-1:0] EZERO = '0;

  logic              adv;
  logic [STAGES:1]   vld_pipe;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  // S1: classify / unpack
  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_m, b_m;
  fp_class_t        a_cls, b_cls;

  log_mul_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .word(in_a), .s(a_s), .e(a_e), .m(a_m), .cls(a_cls)
  );
  log_mul_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .word(in_b), .s(b_s), .e(b_e), .m(b_m), .cls(b_cls)
  );

  logic             s1_s;
  logic [EXP_W-1:0] s1_ea, s1_eb;
  logic [MAN_W-1:0] s1_ma, s1_mb;
  fp_class_t        s1_ca, s1_cb;

  // S2: log-domain add and special-case resolution
  logic [MAN_W:0]   sum;
  logic             carry;
  logic [MAN_W-1:0] man_add;
  logic [EW-1:0]    exp_sum;
  fp_class_t        r_cls;

  assign sum     = {1'b0, s1_ma} + {1'b0, s1_mb};
  assign carry   = sum[MAN_W];
  assign exp_sum = EW'(s1_ea) + EW'(s1_eb) - EW'(BIAS) + EW'(carry);

`ifdef LOG_MUL_CORR_EN
  logic [3:0]     k;
  logic [MAN_W:0] sum_corr;

  // Without a carry S < 2**MAN_W and the correction is < 2**MAN_W, so MAN_W+1 bits hold the sum.
  assign k        = {2'b00, s1_ma[MAN_W-1:MAN_W-2]} * {2'b00, s1_mb[MAN_W-1:MAN_W-2]};
  assign sum_corr = sum + ((MAN_W+1)'(k) << (MAN_W - 4));
  assign man_add  = carry ? sum[MAN_W-1:0] :
                    (sum_corr[MAN_W] ? {MAN_W{1'b1}} : sum_corr[MAN_W-1:0]);
`else
  assign man_add  = sum[MAN_W-1:0];
`endif

  always_comb begin
    r_cls = NORM;
    if (s1_ca == NAN || s1_cb == NAN ||
        (s1_ca == ZERO && s1_cb == INF) || (s1_ca == INF && s1_cb == ZERO))
      r_cls = NAN;
    else if (s1_ca == INF || s1_cb == INF)
      r_cls = INF;
    else if (s1_ca == ZERO || s1_cb == ZERO)
      r_cls = ZERO;
  end

  logic                 s2_s;
  fp_class_t            s2_cls;
  logic signed [EW-1:0] s2_e;
  logic [MAN_W-1:0]     s2_m;

  // S3: antilog / range check / pack
  logic [W-1:0] p_nxt;
  logic [2:0]   f_nxt;

  always_comb begin
    p_nxt = '0;
    f_nxt = '0;
    case (s2_cls)
      NAN: begin
        p_nxt          = QNAN;
        f_nxt[FLAG_NV] = 1'b1;
      end
      INF:  p_nxt = {s2_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ZERO: p_nxt = {s2_s, {(W-1){1'b0}}};
      default: begin
        if (s2_e >= EMAX) begin
          p_nxt          = {s2_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          f_nxt[FLAG_OF] = 1'b1;
        end else if (s2_e <= EZERO) begin
          p_nxt          = {s2_s, {(W-1){1'b0}}};
          f_nxt[FLAG_UF] = 1'b1;
        end else begin
          p_nxt = {s2_s, s2_e[EXP_W-1:0], s2_m};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      out_p     <= '0;
      out_flags <= '0;
    end else if (adv) begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], in_valid};
      out_p     <= p_nxt;
      out_flags <= f_nxt;
    end
  end

  // Payload registers need no reset: they are only observed behind vld_pipe.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_s   <= a_s ^ b_s;
      s1_ea  <= a_e;
      s1_eb  <= b_e;
      s1_ma  <= a_m;
      s1_mb  <= b_m;
      s1_ca  <= a_cls;
      s1_cb  <= b_cls;
      s2_s   <= s1_s;
      s2_cls <= r_cls;
      s2_e   <= exp_sum;
      s2_m   <= man_add;
    end
  end

endmodule

// File: tb/tb_log_fp_mul_pipe.sv
// Self-checking bench for log_fp_mul_pipe (EXP_W=5, MAN_W=10) against an integer reference model.
module tb_log_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_a, in_b, out_p;
  logic [2:0]  out_flags;

  always #5 clk = ~clk;

  log_fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_flags(out_flags)
  );

  int          tests = 0;
  int          fails = 0;
  logic [18:0] exp_q[$];
  int          pushed, popped;
  bit          saw_block;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Reference: {flags[2:0], product[15:0]} from the classification and Mitchell rules.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, e, sm, m, c;
    bit s, za, zb, ia, ib, na, nb;
    ea = int'(a[14:10]); ma = int'(a[9:0]);
    eb = int'(b[14:10]); mb = int'(b[9:0]);
    za = (ea == 0);             zb = (eb == 0);
    ia = (ea == 31 && ma == 0); ib = (eb == 31 && mb == 0);
    na = (ea == 31 && ma != 0); nb = (eb == 31 && mb != 0);
    s  = a[15] ^ b[15];
    if (na || nb || (za && ib) || (ia && zb)) return {3'b100, 16'h7E00};
    if (ia || ib) return {3'b000, s, 15'h7C00};
    if (za || zb) return {3'b000, s, 15'h0000};
    sm = ma + mb;
    c  = (sm >= 1024) ? 1 : 0;
    if (c == 1) m = sm - 1024;
    else begin
      m = sm;
`ifdef LOG_MUL_CORR_EN
      m = sm + (ma / 256) * (mb / 256) * 64;
      if (m > 1023) m = 1023;
`endif
    end
    e = ea + eb - 15 + c;
    if (e >= 31) return {3'b010, s, 15'h7C00};
    if (e <= 0)  return {3'b001, s, 15'h0000};
    return {3'b000, s, 5'(e), 10'(m)};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 7))
      0:       r[14:10] = 5'h00;
      1:       r[14:10] = 5'h1F;
      2:       r[9:0]   = 10'h000;
      default: r[14:10] = 5'($urandom_range(8, 22));
    endcase
    return r;
  endfunction

  // One clock with scoreboard bookkeeping; caller sets inputs just after the previous edge.
  task automatic step(input string tag, output bit acc);
    logic [18:0] w;
    logic [15:0] hp;
    logic [2:0]  hf;
    bit          held;
    #1;
    acc = 1'b0;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk({tag, "_extra"}, exp_q.size(), 1);
      else begin
        w = exp_q.pop_front();
        chk({tag, "_p"}, out_p, w[15:0]);
        chk({tag, "_flags"}, out_flags, w[18:16]);
        popped++;
      end
    end
    if (out_valid && !out_ready) begin
      chk({tag, "_stall_rdy"}, in_ready, 0);
      saw_block = 1'b1;
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(in_a, in_b));
      pushed++;
      acc = 1'b1;
    end
    if (pushed - popped > 3) chk({tag, "_inflight"}, pushed - popped, 3);
    held = out_valid && !out_ready;
    hp   = out_p;
    hf   = out_flags;
    @(posedge clk); #1;
    if (held) begin
      chk({tag, "_hold_v"}, out_valid, 1);
      chk({tag, "_hold_p"}, out_p, hp);
      chk({tag, "_hold_f"}, out_flags, hf);
    end
  endtask

  // Single op into an empty pipe with no back-pressure; checks latency and result.
  task automatic run_one(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] want_p, input logic [2:0] want_f, input string tag);
    int lat;
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_p"}, out_p, want_p);
    chk({tag, "_flags"}, out_flags, want_f);
    @(posedge clk); #1;
  endtask

  logic [15:0] ta[15], tb_[15], tp[15];
  logic [2:0]  tf[15];
  logic [15:0] sa[8], sb[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int c, idx;

    ta  = '{16'h3D00, 16'h3E00, 16'hC000, 16'h7BFF, 16'h0400, 16'h8000, 16'h0000, 16'h7C01,
            16'hFC00, 16'h7C00, 16'hFC00, 16'h0001, 16'h7800, 16'h0400, 16'h4000};
    tb_ = '{16'h3D00, 16'h3E00, 16'h4200, 16'h7BFF, 16'h0400, 16'h3C00, 16'h7C00, 16'h3C00,
            16'h3C00, 16'h7C00, 16'h0000, 16'h3C00, 16'h3C00, 16'h3C00, 16'h7800};
`ifdef LOG_MUL_CORR_EN
    tp[0] = 16'h3E40;
`else
    tp[0] = 16'h3E00;
`endif
    tp[1]  = 16'h4000; tp[2]  = 16'hC600; tp[3]  = 16'h7C00; tp[4]  = 16'h0000;
    tp[5]  = 16'h8000; tp[6]  = 16'h7E00; tp[7]  = 16'h7E00; tp[8]  = 16'hFC00;
    tp[9]  = 16'h7C00; tp[10] = 16'h7E00; tp[11] = 16'h0000; tp[12] = 16'h7800;
    tp[13] = 16'h0400; tp[14] = 16'h7C00;
    tf = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b000, 3'b100, 3'b100,
           3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b010};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_p", out_p, 0);
    chk("rst_flags", out_flags, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++)
      run_one(ta[i], tb_[i], tp[i], tf[i], $sformatf("dir%0d", i));

    // Back-to-back stream with downstream stalled on cycles 4-8
    for (int i = 0; i < 8; i++) begin sa[i] = rand_op(); sb[i] = rand_op(); end
    exp_q.delete(); pushed = 0; popped = 0; saw_block = 1'b0;
    c = 0; idx = 0;
    while (popped < 8 && c < 200) begin
      c++;
      in_valid  = (idx < 8);
      in_a      = sa[idx < 8 ? idx : 0];
      in_b      = sb[idx < 8 ? idx : 0];
      out_ready = !(c >= 4 && c <= 8);
      step("stream", acc);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("stream_pushed", pushed, 8);
    chk("stream_popped", popped, 8);
    chk("stream_blocked", saw_block, 1);

    // Randomised traffic with random back-pressure
    exp_q.delete(); pushed = 0; popped = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = rand_op();
      in_b      = rand_op();
      out_ready = ($urandom_range(0, 2) != 0);
      step("rand", acc);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    c = 0;
    while (exp_q.size() != 0 && c < 20) begin
      c++;
      step("drain", acc);
    end
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_count", popped, pushed);
    @(posedge clk); #1;

    // Reset pulse with two ops in flight
    in_valid = 1'b1; out_ready = 1'b1;
    in_a = 16'h3C00; in_b = 16'h4000;
    @(posedge clk); #1;
    in_a = 16'h4200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("midrst_valid%0d", i), out_valid, 0);
      @(posedge clk); #1;
    end
    run_one(16'h3E00, 16'h3E00, 16'h4000, 3'b000, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
